// File: rtl/bin_clock_core.sv
// Binary-clock timekeeping core: prescaled 1 Hz tick, 24 h h:m:s counters,
// debounced-by-synchronizer set button and a selectable 8-bit display field.
module bin_clock_core #(
   parameter int unsigned DIV   = 10_000_000,
   parameter int unsigned DIV_W = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [1:0] set_mode,
   input  logic       inc_btn,
   input  logic [1:0] disp_sel,
   output logic [7:0] disp,
   output logic [4:0] hour,
   output logic [5:0] min,
   output logic [5:0] sec,
   output logic       sec_pulse
);

   localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

   logic             r_s1, r_s2, r_s3;
   logic [1:0]       r_fill;
   logic             r_armed;
   logic [DIV_W-1:0] r_presc;
   logic [4:0]       r_hour;
   logic [5:0]       r_min;
   logic [5:0]       r_sec;
   logic             r_pulse;

   logic w_run;
   logic w_tick;
   logic w_inc;

   assign w_run  = (set_mode == 2'b00);
   assign w_tick = w_run & ena & (r_presc == LAST);
   // r_armed blocks a press already held when reset was released.
   assign w_inc  = r_s2 & ~r_s3 & r_armed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_s3    <= 1'b0;
         r_fill  <= 2'd0;
         r_armed <= 1'b0;
      end else begin
         r_s1 <= inc_btn;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         if (r_fill != 2'd2)
            r_fill <= r_fill + 2'd1;
         // s2 only holds a real button sample once two edges have passed.
         if (r_fill == 2'd2 && !r_s2)
            r_armed <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
      end else if (!w_run) begin
         r_presc <= '0;
      end else if (ena) begin
         r_presc <= (r_presc == LAST) ? '0 : r_presc + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hour  <= 5'd0;
         r_min   <= 6'd0;
         r_sec   <= 6'd0;
         r_pulse <= 1'b0;
      end else begin
         r_pulse <= w_tick;
         if (w_tick) begin
            if (r_sec == 6'd59) begin
               r_sec <= 6'd0;
               if (r_min == 6'd59) begin
                  r_min  <= 6'd0;
                  r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
               end else begin
                  r_min <= r_min + 6'd1;
               end
            end else begin
               r_sec <= r_sec + 6'd1;
            end
         end else if (w_inc) begin
            case (set_mode)
               2'b01:   r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
               2'b10:   r_min  <= (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
               2'b11:   r_sec  <= 6'd0;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      disp = 8'd0;
      case (disp_sel)
         2'b00:   disp = {2'b00, r_sec};
         2'b01:   disp = {2'b00, r_min};
         2'b10:   disp = {3'b000, r_hour};
         default: disp = {ena, set_mode, 5'b00000};
      endcase
   end

   assign hour      = r_hour;
   assign min       = r_min;
   assign sec       = r_sec;
   assign sec_pulse = r_pulse;

endmodule

// File: tb/tb_bin_clock_core.sv
// Self-checking bench for bin_clock_core (DIV=4): directed scenarios plus a
// randomized phase, all compared against a seconds-of-day reference model.
module tb_bin_clock_core;

   localparam int DIV = 4;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [1:0] set_mode;
   logic       inc_btn;
   logic [1:0] disp_sel;
   logic [7:0] disp;
   logic [4:0] hour;
   logic [5:0] min;
   logic [5:0] sec;
   logic       sec_pulse;

   int checks = 0;
   int errors = 0;

   // reference model state
   int m_h, m_m, m_s, m_ph, m_edges;
   bit m_pulse;
   bit samp[$];

   bin_clock_core #(.DIV(DIV), .DIV_W(24)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .set_mode  (set_mode),
      .inc_btn   (inc_btn),
      .disp_sel  (disp_sel),
      .disp      (disp),
      .hour      (hour),
      .min       (min),
      .sec       (sec),
      .sec_pulse (sec_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int disp_model();
      case (disp_sel)
         2'd0:    return m_s;
         2'd1:    return m_m;
         2'd2:    return m_h;
         default: return (ena ? 128 : 0) + 32 * int'(set_mode);
      endcase
   endfunction

   task automatic check_all(input string tag);
      chk({tag, "_hour"},  hour,      m_h);
      chk({tag, "_min"},   min,       m_m);
      chk({tag, "_sec"},   sec,       m_s);
      chk({tag, "_pulse"}, sec_pulse, m_pulse);
      chk({tag, "_disp"},  disp,      disp_model());
   endtask

   task automatic model_reset();
      m_h = 0; m_m = 0; m_s = 0; m_ph = 0; m_edges = 0; m_pulse = 0;
      samp.delete();
   endtask

   // One clock edge: predict from pre-edge inputs, then compare after the edge.
   task automatic cyc();
      int e, ph_n, mode, tod;
      bit inc, run, tick, en;
      e    = m_edges + 1;
      mode = int'(set_mode);
      en   = ena;
      // a press counts when two real samples show the button rising
      inc  = (e >= 4) && samp[e-3] && !samp[e-4];
      run  = (mode == 0);
      tick = run && en && (m_ph == DIV - 1);
      ph_n = !run ? 0 : (en ? (m_ph + 1) % DIV : m_ph);
      @(posedge clk);
      samp.push_back(inc_btn);
      m_edges = e;
      m_ph    = ph_n;
      m_pulse = tick;
      if (tick) begin
         tod = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
         m_h = tod / 3600;
         m_m = (tod / 60) % 60;
         m_s = tod % 60;
      end else if (inc) begin
         case (mode)
            1: m_h = (m_h + 1) % 24;
            2: m_m = (m_m + 1) % 60;
            3: m_s = 0;
            default: ;
         endcase
      end
      #1;
      check_all("cyc");
   endtask

   task automatic press(input int len);
      inc_btn = 1'b1;
      repeat (len) cyc();
      inc_btn = 1'b0;
      repeat (3) cyc();
   endtask

   task automatic set_time(input int h, input int m);
      int nh, nm;
      set_mode = 2'd3;
      press(2);
      nh = (h - m_h + 24) % 24;
      set_mode = 2'd1;
      repeat (nh) press(2);
      nm = (m - m_m + 60) % 60;
      set_mode = 2'd2;
      repeat (nm) press(2);
      set_mode = 2'd0;
      $display("set_time %02d:%02d:%02d", m_h, m_m, m_s);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; ena = 1'b1; set_mode = 2'd0; inc_btn = 1'b0; disp_sel = 2'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all("init_rst");
      @(negedge clk);
      rst_n = 1'b1;

      // free run from release
      for (int i = 1; i <= 12; i++) begin
         cyc();
         chk("run_pulse", sec_pulse, (i % 4 == 0) ? 1 : 0);
      end
      chk("run_sec12", sec, 3);
      $display("run 12 cycles sec=%0d", sec);

      // 23:59:59 -> 00:00:00
      set_time(23, 59);
      ena = 1'b1;
      repeat (236) cyc();
      chk("pre_wrap_h", hour, 23);
      chk("pre_wrap_m", min, 59);
      chk("pre_wrap_s", sec, 59);
      for (int i = 1; i <= 4; i++) begin
         cyc();
         chk("wrap_pulse", sec_pulse, (i == 4) ? 1 : 0);
      end
      chk("wrap_h", hour, 0);
      chk("wrap_m", min, 0);
      chk("wrap_s", sec, 0);
      cyc();
      chk("wrap_pulse_end", sec_pulse, 0);
      $display("wrap to %02d:%02d:%02d", hour, min, sec);

      // minute set with a long press, no carry into hour
      set_time(5, 59);
      set_mode = 2'd2;
      inc_btn  = 1'b1;
      cyc(); chk("min_edgeN", min, 59);
      cyc(); chk("min_edgeN1", min, 59);
      cyc(); chk("min_edgeN2", min, 0);
      chk("min_hour_kept", hour, 5);
      repeat (17) cyc();
      inc_btn = 1'b0;
      repeat (3) cyc();
      chk("min_one_inc", min, 0);
      $display("min long press -> %02d:%02d", hour, min);

      // zero seconds at 37, then run and freeze
      set_mode = 2'd0; ena = 1'b1;
      n = 0;
      while (m_s != 37 && n < 400) begin cyc(); n++; end
      chk("reach37_bound", (n < 400) ? 1 : 0, 1);
      chk("sec37", sec, 37);
      set_mode = 2'd3;
      press(2);
      chk("zero_sec", sec, 0);
      set_mode = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         cyc();
         chk("zero_next_tick", sec_pulse, (i == 4) ? 1 : 0);
      end
      chk("zero_sec1", sec, 1);
      ena = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("frozen_sec", sec, 1);
         chk("frozen_pulse", sec_pulse, 0);
      end
      $display("zero seconds / ena freeze sec=%0d", sec);

      // display sweep at 13:45:07
      set_time(13, 45);
      ena = 1'b1;
      repeat (28) cyc();
      disp_sel = 2'd0; #1; chk("disp_sec",  disp, 8'h07);
      disp_sel = 2'd1; #1; chk("disp_min",  disp, 8'h2D);
      disp_sel = 2'd2; #1; chk("disp_hour", disp, 8'h0D);
      disp_sel = 2'd3; #1; chk("disp_stat", disp, 8'h80);
      disp_sel = 2'd0;
      $display("disp sweep at %02d:%02d:%02d", hour, min, sec);

      // randomized phase
      for (int i = 0; i < 400; i++) begin
         int r;
         r = int'($urandom_range(0, 9));
         set_mode = (r < 6) ? 2'd0 : 2'(r - 6);
         ena      = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 3) == 0) inc_btn = ~inc_btn;
         disp_sel = 2'($urandom_range(0, 3));
         cyc();
      end
      $display("random phase done at %02d:%02d:%02d", m_h, m_m, m_s);

      // async reset with a press in flight, press still held at release
      disp_sel = 2'd0; set_mode = 2'd1; ena = 1'b1; inc_btn = 1'b0;
      repeat (3) cyc();
      inc_btn = 1'b1;
      cyc();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) cyc();
      chk("held_no_inc", hour, 0);
      inc_btn = 1'b0;
      repeat (2) cyc();
      press(2);
      chk("after_release_inc", hour, 1);
      $display("reset-in-flight hour=%0d", hour);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
